// File: rtl/agdc_pkg.sv
// Shared state/command encodings and PWM helper for the garage-door motor driver.
// Pure definitions; no logic, latency or flow control.
package agdc_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DEAD  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_UP   = 2'd1,
    CMD_DN   = 2'd2
  } cmd_t;

  function automatic int pwm_max(input int pwm_bits);
    return (1 << pwm_bits) - 1;
  endfunction

endpackage

// File: rtl/agdc_motor_drv_pwm_gen.sv
// Soft-start PWM: free-running counter, duty stepping every RAMP_STEP_CYC cycles, compare.
// clr forces duty=1 with counters at 0 on the next edge; done flags the last ramp cycle; no backpressure.
module agdc_pwm_gen
  import agdc_pkg::*;
#(
  parameter int PWM_BITS      = 4,
  parameter int RAMP_STEP_CYC = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clr,
  input  logic                en,
  output logic [PWM_BITS-1:0] duty,
  output logic                pwm_on,
  output logic                done
);

  localparam int SW = $clog2(RAMP_STEP_CYC + 1);
  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(pwm_max(PWM_BITS));

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;
  logic [SW-1:0]       step_cnt;
  logic                step_last;

  assign step_last = (step_cnt == SW'(RAMP_STEP_CYC - 1));
  assign done      = en && step_last && (duty_q == DMAX);
  assign pwm_on    = (pwm_cnt < duty_q);
  assign duty      = duty_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      duty_q   <= '0;
    end else if (clr) begin
      pwm_cnt  <= '0;
      step_cnt <= '0;
      duty_q   <= PWM_BITS'(1);
    end else if (en) begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (step_last) begin
        step_cnt <= '0;
        if (duty_q != DMAX) duty_q <= duty_q + PWM_BITS'(1);
      end else begin
        step_cnt <= step_cnt + SW'(1);
      end
    end
  end

endmodule

// File: rtl/agdc_motor_drv.sv
// H-bridge driver with dead-time, brake, run-timeout fault; soft-start ramp only with AGDC_DRV_SOFTSTART_EN.
// Outputs decode registered state (command seen on one edge acts from the next cycle); commands are levels, no backpressure.
module agdc_motor_drv
  import agdc_pkg::*;
#(
  parameter int DEAD_CYC      = 16,
  parameter int PWM_BITS      = 4,
  parameter int RAMP_STEP_CYC = 8,
  parameter int TMO_CYC       = 4096
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                UP_M,
  input  logic                DN_M,
  input  logic                FAULT_CLR,
  output logic                MOT_UP,
  output logic                MOT_DN,
  output logic                BRAKE,
  output logic                FAULT,
  output logic [PWM_BITS-1:0] DUTY
);

  localparam int DW = $clog2(DEAD_CYC + 1);
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [PWM_BITS-1:0] DMAX = PWM_BITS'(pwm_max(PWM_BITS));

  state_t state, state_nxt;
  cmd_t   cmd, dir, dir_nxt;
  logic [DW-1:0] dead_cnt, dead_nxt;
  logic [TW-1:0] tmo_cnt;
  logic drive, tmo_hit, ramp_done, pwm_on;
  logic [PWM_BITS-1:0] duty_ramp;

`ifdef AGDC_DRV_SOFTSTART_EN
  agdc_pwm_gen #(
    .PWM_BITS      (PWM_BITS),
    .RAMP_STEP_CYC (RAMP_STEP_CYC)
  ) u_pwm_gen (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (state != ST_RAMP),
    .en     (state == ST_RAMP),
    .duty   (duty_ramp),
    .pwm_on (pwm_on),
    .done   (ramp_done)
  );
`else
  // RAMP is unreachable in this build; these only keep the shared decode well-formed.
  assign ramp_done = (RAMP_STEP_CYC < 1);
  assign pwm_on    = 1'b0;
  assign duty_ramp = '0;
`endif

  assign drive   = (state == ST_RAMP) || (state == ST_RUN);
  assign tmo_hit = drive && (tmo_cnt == TW'(TMO_CYC - 1));

  always_comb begin
    cmd = CMD_NONE;
    if (UP_M && !DN_M)      cmd = CMD_UP;
    else if (DN_M && !UP_M) cmd = CMD_DN;
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    dead_nxt  = dead_cnt;
    case (state)
      ST_OFF: begin
        if (cmd != CMD_NONE) begin
          state_nxt = ST_DEAD;
          dir_nxt   = cmd;
          dead_nxt  = DW'(DEAD_CYC - 1);
        end
      end
      ST_DEAD: begin
        if (cmd == CMD_NONE) begin
          state_nxt = ST_OFF;
        end else if (cmd != dir) begin
          dir_nxt  = cmd;
          dead_nxt = DW'(DEAD_CYC - 1);
        end else if (dead_cnt == '0) begin
`ifdef AGDC_DRV_SOFTSTART_EN
          state_nxt = ST_RAMP;
`else
          state_nxt = ST_RUN;
`endif
        end else begin
          dead_nxt = dead_cnt - DW'(1);
        end
      end
      ST_RAMP, ST_RUN: begin
        // Timeout wins over any simultaneous command change.
        if (tmo_hit) begin
          state_nxt = ST_FAULT;
        end else if (cmd == CMD_NONE) begin
          state_nxt = ST_OFF;
        end else if (cmd != dir) begin
          state_nxt = ST_DEAD;
          dir_nxt   = cmd;
          dead_nxt  = DW'(DEAD_CYC - 1);
        end else if (state == ST_RAMP && ramp_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (FAULT_CLR && cmd == CMD_NONE) state_nxt = ST_OFF;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_OFF;
      dir      <= CMD_NONE;
      dead_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      dir      <= dir_nxt;
      dead_cnt <= dead_nxt;
      tmo_cnt  <= drive ? tmo_cnt + TW'(1) : '0;
    end
  end

  always_comb begin
    MOT_UP = 1'b0;
    MOT_DN = 1'b0;
    DUTY   = '0;
    BRAKE  = !drive;
    FAULT  = (state == ST_FAULT);
    if (state == ST_RUN) begin
      MOT_UP = (dir == CMD_UP);
      MOT_DN = (dir == CMD_DN);
      DUTY   = DMAX;
    end else if (state == ST_RAMP) begin
      MOT_UP = (dir == CMD_UP) && pwm_on;
      MOT_DN = (dir == CMD_DN) && pwm_on;
      DUTY   = duty_ramp;
    end
  end

endmodule

// File: tb/tb_agdc_motor_drv.sv
// Self-checking bench: directed scenarios with literal expectations plus random command streams,
// all outputs compared every cycle against a drive-age based behavioural model.
module tb_agdc_motor_drv;

  localparam int DEAD  = 4;
  localparam int PB    = 4;
  localparam int STEP  = 2;
  localparam int TMO   = 100;
  localparam int PMAX  = 15;
  localparam int PER   = 16;
`ifdef AGDC_DRV_SOFTSTART_EN
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif
  localparam int RAMP_LEN = SOFT ? PMAX * STEP : 0;

  localparam int M_IDLE  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_DRIVE = 2;
  localparam int M_FLT   = 3;

  logic CLK = 1'b0;
  logic RST, UP_M, DN_M, FAULT_CLR;
  logic MOT_UP, MOT_DN, BRAKE, FAULT;
  logic [PB-1:0] DUTY;

  agdc_motor_drv #(
    .DEAD_CYC      (DEAD),
    .PWM_BITS      (PB),
    .RAMP_STEP_CYC (STEP),
    .TMO_CYC       (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .UP_M      (UP_M),
    .DN_M      (DN_M),
    .FAULT_CLR (FAULT_CLR),
    .MOT_UP    (MOT_UP),
    .MOT_DN    (MOT_DN),
    .BRAKE     (BRAKE),
    .FAULT     (FAULT),
    .DUTY      (DUTY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit model_ok = 1'b0;
  int m_mode = M_IDLE;
  int m_dir = 0;
  int m_left = 0;
  int m_age = 0;
  int last_up = -1000;
  int last_dn = -1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  function automatic int cmd_of(input logic up, input logic dn);
    if (up && !dn) return 1;
    if (dn && !up) return -1;
    return 0;
  endfunction

  function automatic bit leg_on(input int age);
    if (age >= RAMP_LEN) return 1'b1;
    return (age % PER) < (1 + age / STEP);
  endfunction

  function automatic int duty_of(input int age);
    if (age >= RAMP_LEN) return PMAX;
    return 1 + age / STEP;
  endfunction

  // Behavioural model: advances on each edge from the inputs held during the cycle.
  always @(posedge CLK) begin
    int c;
    cyc++;
    c = cmd_of(UP_M, DN_M);
    if (RST) begin
      m_mode = M_IDLE;
      m_age = 0;
      model_ok = 1'b1;
    end else begin
      case (m_mode)
        M_IDLE: if (c != 0) begin m_mode = M_WAIT; m_dir = c; m_left = DEAD; end
        M_WAIT: begin
          if (c == 0) m_mode = M_IDLE;
          else if (c != m_dir) begin m_dir = c; m_left = DEAD; end
          else begin
            m_left--;
            if (m_left == 0) begin m_mode = M_DRIVE; m_age = 0; end
          end
        end
        M_DRIVE: begin
          if (m_age + 1 == TMO) m_mode = M_FLT;
          else if (c == 0) m_mode = M_IDLE;
          else if (c != m_dir) begin m_mode = M_WAIT; m_dir = c; m_left = DEAD; end
          else m_age++;
        end
        default: if (FAULT_CLR && c == 0) m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      bit drv;
      drv = (m_mode == M_DRIVE);
      chk("mot_up", MOT_UP, drv && m_dir == 1 && leg_on(m_age));
      chk("mot_dn", MOT_DN, drv && m_dir == -1 && leg_on(m_age));
      chk("brake", BRAKE, !drv);
      chk("fault", FAULT, m_mode == M_FLT);
      chk("duty", DUTY, drv ? duty_of(m_age) : 0);
      chk("legs_exclusive", MOT_UP & MOT_DN, 0);
      if (MOT_UP === 1'b1) begin
        chk("dead_before_up", (cyc - last_dn) > DEAD, 1);
        last_up = cyc;
      end
      if (MOT_DN === 1'b1) begin
        chk("dead_before_dn", (cyc - last_up) > DEAD, 1);
        last_dn = cyc;
      end
    end
  end

  initial begin
    RST = 1'b1; UP_M = 1'b0; DN_M = 1'b0; FAULT_CLR = 1'b0;
    tick(2);
    chk("rst_mot_up", MOT_UP, 0);
    chk("rst_mot_dn", MOT_DN, 0);
    chk("rst_brake", BRAKE, 1);
    chk("rst_fault", FAULT, 0);
    chk("rst_duty", DUTY, 0);
    RST = 1'b0;
    tick(1);

    // Start-up: command in cycle 0, dead cycles 1-4, drive from cycle 5.
    UP_M = 1'b1;
    tick(4);
    chk("start_dead_up", MOT_UP, 0);
    chk("start_dead_brake", BRAKE, 1);
    tick(1);
    chk("start_first_up", MOT_UP, 1);
    chk("start_first_duty", DUTY, SOFT ? 1 : 15);
    tick(1);
    chk("start_pwm_low", MOT_UP, SOFT ? 0 : 1);
    tick(1);
    chk("start_duty_c7", DUTY, SOFT ? 2 : 15);
    tick(28);
    chk("run_up", MOT_UP, 1);
    chk("run_duty", DUTY, 15);

    // Reversal from RUN.
    tick(5);
    UP_M = 1'b0; DN_M = 1'b1;
    tick(1);
    chk("rev_up_off", MOT_UP, 0);
    chk("rev_dn_off", MOT_DN, 0);
    tick(4);
    chk("rev_dn_on", MOT_DN, 1);
    chk("rev_dn_duty", DUTY, SOFT ? 1 : 15);

    // Both commands high is a stop.
    tick(3);
    UP_M = 1'b1;
    tick(1);
    chk("both_brake", BRAKE, 1);
    chk("both_duty", DUTY, 0);
    chk("both_dn", MOT_DN, 0);

    // Timeout: drive starts 5 cycles after the command, fault after 100 drive cycles.
    UP_M = 1'b0; DN_M = 1'b1;
    tick(104);
    chk("tmo_last_fault", FAULT, 0);
    chk("tmo_last_dn", MOT_DN, 1);
    tick(1);
    chk("tmo_fault", FAULT, 1);
    chk("tmo_dn_off", MOT_DN, 0);
    chk("tmo_brake", BRAKE, 1);
    FAULT_CLR = 1'b1;
    tick(3);
    chk("tmo_clr_ignored", FAULT, 1);
    DN_M = 1'b0;
    tick(1);
    chk("tmo_cleared", FAULT, 0);
    chk("tmo_clr_brake", BRAKE, 1);
    FAULT_CLR = 1'b0;
    tick(2);

    // Dead restart: direction switched during dead cycle 3.
    UP_M = 1'b1;
    tick(3);
    UP_M = 1'b0; DN_M = 1'b1;
    tick(4);
    chk("restart_still_dead", MOT_DN | MOT_UP, 0);
    tick(1);
    chk("restart_dn_on", MOT_DN, 1);

    // Reset in the middle of RUN.
    tick(40);
    RST = 1'b1;
    tick(1);
    chk("midrst_dn", MOT_DN, 0);
    chk("midrst_brake", BRAKE, 1);
    chk("midrst_duty", DUTY, 0);
    RST = 1'b0; DN_M = 1'b0;
    tick(2);

    // Random command streams; the per-cycle model comparison does the checking.
    for (int seg = 0; seg < 60; seg++) begin
      int r, len;
      r = $urandom_range(0, 9);
      UP_M = (r <= 3) || (r == 9);
      DN_M = (r >= 4 && r <= 7) || (r == 9);
      len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 8) : $urandom_range(9, 130);
      for (int c = 0; c < len; c++) begin
        FAULT_CLR = ($urandom_range(0, 3) == 0);
        RST = ($urandom_range(0, 299) == 0);
        tick(1);
      end
    end
    RST = 1'b0; UP_M = 1'b0; DN_M = 1'b0; FAULT_CLR = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
